ddr_cmd_queue: RTL and testbench

DDR_CMD_QUEUE -- requirements
Module: ddr_cmd_queue

---
 rtl/ddr_cmd_queue_pkg.sv | 18 +
 rtl/cmd_fifo.sv | 41 ++++
 rtl/ddr_cmd_queue.sv | 55 +++++
 tb/tb_ddr_cmd_queue.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_queue_pkg.sv
// ddr_cmd_queue_pkg: command word layout and queue defaults shared by the DDR command queue
package ddr_cmd_queue_pkg;
  localparam int CMD_W = 34;
  localparam int DEPTH_DEF = 8;
  localparam int ALT_CMD_HI = 33;
  localparam int ALT_CMD_LO = 31;
  localparam int CMD_HI = 30;
  localparam int CMD_LO = 28;
  localparam int SPARE_HI = 27;
  localparam int RANK_BIT = 26;
  localparam int ROW_HI = 25;
  localparam int ROW_LO = 12;
  localparam int BANK_HI = 11;
  localparam int BANK_LO = 9;
  localparam int SPARE_LO = 8;
  localparam int COL_HI = 7;
  localparam int COL_LO = 0;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: generic synchronous first-word-fall-through FIFO with flush and distributed storage
module cmd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     Ph0,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign doPop = pop & ~empty & ~flush;
  assign doPush = push & ~flush & (~full | doPop);
  assign rdData = mem[rdPtr];
  // storage write; contents are intentionally never cleared
  always_ff @(posedge Ph0)
    if (doPush) mem[wrPtr] <= wrData;
  // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge Ph0)
    if (Reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
endmodule

// File: rtl/ddr_cmd_queue.sv
// ddr_cmd_queue: queues TinyComp command words and presents decoded DDR fields to the controller
module ddr_cmd_queue
  import ddr_cmd_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   Ph0,
  input  logic                   Reset,
  input  logic [CMD_W-1:0]       LastALU,
  input  logic                   injectTC5address,
  input  logic                   InhibitDDR,
  input  logic                   clrOverflow,
  input  logic                   afReady,
  output logic                   afValid,
  output logic [2:0]             afCmd,
  output logic [2:0]             afAltCmd,
  output logic [13:0]            afRow,
  output logic [2:0]             afBank,
  output logic                   afRank,
  output logic [13:0]            afCol,
  output logic [$clog2(DEPTH):0] qCount,
  output logic                   qFull,
  output logic                   qEmpty,
  output logic                   overflow
);
  logic [CMD_W-1:0] head;
  logic push, pop, unusedSpare;
  assign afValid = ~qEmpty & ~InhibitDDR;
  assign pop = afValid & afReady;
  assign push = injectTC5address & ~InhibitDDR & (~qFull | pop);
  assign afAltCmd = head[ALT_CMD_HI:ALT_CMD_LO];
  assign afCmd = head[CMD_HI:CMD_LO];
  assign afRank = head[RANK_BIT];
  assign afRow = head[ROW_HI:ROW_LO];
  assign afBank = head[BANK_HI:BANK_LO];
  assign afCol = {4'b0, head[COL_HI:COL_LO], 2'b0};
  assign unusedSpare = ^{head[SPARE_HI], head[SPARE_LO]};
  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) uFifo (
    .Ph0(Ph0),
    .Reset(Reset),
    .push(push),
    .pop(pop),
    .flush(InhibitDDR),
    .wrData(LastALU),
    .rdData(head),
    .count(qCount),
    .full(qFull),
    .empty(qEmpty)
  );
  // sticky drop flag; a dropped strobe beats a simultaneous clear
  always_ff @(posedge Ph0)
    if (Reset) overflow <= 1'b0;
    else if (injectTC5address && !InhibitDDR && !push) overflow <= 1'b1;
    else if (clrOverflow) overflow <= 1'b0;
endmodule

// File: tb/tb_ddr_cmd_queue.sv
// tb_ddr_cmd_queue: scoreboard bench for the DDR command queue with directed vectors
module tb_ddr_cmd_queue;
  logic Ph0 = 1'b0;
  logic Reset, injectTC5address, InhibitDDR, clrOverflow, afReady;
  logic [33:0] LastALU;
  logic afValid, afRank, qFull, qEmpty, overflow;
  logic [2:0] afCmd, afAltCmd, afBank;
  logic [13:0] afRow, afCol;
  logic [3:0] qCount;
  logic [33:0] expQ[$];
  int nVec = 0;
  int nBad = 0;

  ddr_cmd_queue #(.DEPTH(8)) dut (
    .Ph0(Ph0), .Reset(Reset), .LastALU(LastALU), .injectTC5address(injectTC5address),
    .InhibitDDR(InhibitDDR), .clrOverflow(clrOverflow), .afReady(afReady),
    .afValid(afValid), .afCmd(afCmd), .afAltCmd(afAltCmd), .afRow(afRow),
    .afBank(afBank), .afRank(afRank), .afCol(afCol), .qCount(qCount),
    .qFull(qFull), .qEmpty(qEmpty), .overflow(overflow)
  );

  always #5 Ph0 = ~Ph0;

  function automatic logic [37:0] decode(logic [33:0] w);
    return {w[33:31], w[30:28], w[26], w[25:12], w[11:9], 4'b0, w[7:0], 2'b0};
  endfunction

  task automatic chk(string nm, int act, int req);
    nVec++;
    if (act != req) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Ph0);
    #1;
  endtask

  task automatic strobe(logic [33:0] w, bit expect_push);
    injectTC5address = 1'b1;
    LastALU = w;
    if (expect_push) expQ.push_back(w);
    tick();
    injectTC5address = 1'b0;
  endtask

  // monitor: every accepted head entry must match the oldest expected word
  always @(negedge Ph0) begin
    logic [33:0] w;
    if (afValid === 1'b1 && afReady === 1'b1) begin
      nVec++;
      if (expQ.size() == 0) begin
        nBad++;
        $display("FAIL pop: unexpected entry cmd=%0h row=%0h col=%0h", afCmd, afRow, afCol);
      end else begin
        w = expQ.pop_front();
        if ({afAltCmd, afCmd, afRank, afRow, afBank, afCol} !== decode(w)) begin
          nBad++;
          $display("FAIL pop: got %0h expected %0h (word %0h)",
                   {afAltCmd, afCmd, afRank, afRow, afBank, afCol}, decode(w), w);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; injectTC5address = 1'b0; InhibitDDR = 1'b0;
    clrOverflow = 1'b0; afReady = 1'b0; LastALU = '0;
    tick(); tick();
    Reset = 1'b0;
    chk("reset qCount", int'(qCount), 0);
    chk("reset qEmpty", int'(qEmpty), 1);
    chk("reset qFull", int'(qFull), 0);
    chk("reset afValid", int'(afValid), 0);
    chk("reset overflow", int'(overflow), 0);
    afReady = 1'b1;
    strobe(34'h2_C5A5_A3FF, 1'b1);
    chk("decode afValid", int'(afValid), 1);
    chk("decode afAltCmd", int'(afAltCmd), 3'b101);
    chk("decode afCmd", int'(afCmd), 3'b100);
    chk("decode afRank", int'(afRank), 1);
    chk("decode afRow", int'(afRow), 14'h1A5A);
    chk("decode afBank", int'(afBank), 3'b001);
    chk("decode afCol", int'(afCol), 14'h03FC);
    tick();
    chk("decode qEmpty", int'(qEmpty), 1);
    chk("decode afValid after pop", int'(afValid), 0);
    afReady = 1'b0;
    for (int i = 1; i <= 9; i++) strobe(34'(i), i <= 8);
    chk("fill qFull", int'(qFull), 1);
    chk("fill qCount", int'(qCount), 8);
    chk("fill overflow", int'(overflow), 1);
    clrOverflow = 1'b1;
    strobe(34'd99, 1'b0);
    clrOverflow = 1'b0;
    chk("race overflow", int'(overflow), 1);
    chk("race qCount", int'(qCount), 8);
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    chk("clear overflow", int'(overflow), 0);
    afReady = 1'b1;
    strobe(34'd10, 1'b1);
    chk("simul qCount", int'(qCount), 8);
    chk("simul overflow", int'(overflow), 0);
    for (int i = 0; i < 20 && qEmpty !== 1'b1; i++) tick();
    chk("drain qEmpty", int'(qEmpty), 1);
    chk("drain afValid", int'(afValid), 0);
    chk("drain scoreboard", expQ.size(), 0);
    afReady = 1'b0;
    for (int i = 21; i <= 23; i++) strobe(34'(i), 1'b1);
    chk("inhibit pre qCount", int'(qCount), 3);
    InhibitDDR = 1'b1;
    expQ.delete();
    injectTC5address = 1'b1;
    LastALU = 34'd30;
    tick();
    chk("inhibit afValid", int'(afValid), 0);
    chk("inhibit qCount", int'(qCount), 0);
    tick();
    chk("inhibit qCount 2", int'(qCount), 0);
    chk("inhibit overflow", int'(overflow), 0);
    InhibitDDR = 1'b0;
    strobe(34'd31, 1'b1);
    chk("inhibit release qCount", int'(qCount), 1);
    afReady = 1'b1;
    tick();
    chk("inhibit drain qEmpty", int'(qEmpty), 1);
    afReady = 1'b0;
    for (int i = 41; i <= 49; i++) strobe(34'(i), i <= 48);
    chk("reset pre overflow", int'(overflow), 1);
    afReady = 1'b1;
    tick(); tick(); tick();
    chk("reset pre qCount", int'(qCount), 5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    afReady = 1'b0;
    expQ.delete();
    chk("reset qCount 5", int'(qCount), 0);
    chk("reset afValid 5", int'(afValid), 0);
    chk("reset overflow 5", int'(overflow), 0);
    chk("reset qEmpty 5", int'(qEmpty), 1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
